msrv32_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the msrv32 core. It owns the program counter and drives a single-outstanding request/grant/response instruction-memory port. It applies PC redirects from the branch unit (branch_taken) and from trap logic, discards in-flight fetches made stale by a redirect, and hands instructions to decode with a valid/stall handshake.

---
 rtl/msrv32_fetch_pkg.sv | 15 +
 rtl/msrv32_next_pc.sv | 36 +++
 rtl/msrv32_fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_msrv32_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_fetch_pkg.sv
// msrv32 fetch: shared constants.
// State encodings, NOP word and PC step.
package msrv32_fetch_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/msrv32_next_pc.sv
// msrv32 fetch: next-PC select.
// Trap > aligned branch > PC+4 > hold.
module msrv32_next_pc
  import msrv32_fetch_pkg::*;
(
  input  logic        i_trap,
  input  logic [31:0] i_trap_addr,
  input  logic        i_branch,
  input  logic [31:0] i_target,
  input  logic [31:0] i_pc,
  input  logic        i_adv,
  output logic        o_redir,
  output logic        o_mis,
  output logic [31:0] o_tgt,
  output logic [31:0] o_next_pc
);

  logic w_bad;

  assign w_bad   = |i_target[1:0];
  assign o_mis   = i_branch & ~i_trap & w_bad;
  assign o_redir = i_trap | (i_branch & ~w_bad);
  assign o_tgt   = i_trap ? (i_trap_addr & ~32'h3)
                          : i_target;

  // pick redirect target, sequential step or hold
  always_comb begin
    o_next_pc = i_pc;
    unique case (1'b1)
      o_redir:          o_next_pc = o_tgt;
      (~o_redir & i_adv): o_next_pc = i_pc + PC_INC;
      default:          o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// msrv32 fetch: PC owner and imem sequencer.
// One outstanding fetch, redirect, drop, halt.
module msrv32_fetch_ctrl
  import msrv32_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_addr_in,
  input  logic        stall_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        misaligned_exc_out,
  output logic [31:0] misaligned_addr_out
);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic        r_to_halt;
  logic        r_pend;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_mis_exc;
  logic [31:0] r_mis_addr;

  logic        w_redir;
  logic        w_mis;
  logic        w_any;
  logic        w_adv;
  logic        w_eff_halt;
  logic [31:0] w_tgt;
  logic [31:0] w_next_pc;
  logic [31:0] w_eff_tgt;

  assign w_any      = w_redir | w_mis;
  assign w_adv      = (r_state == S_HOLD) & ~stall_in;
  assign w_eff_halt = w_any ? w_mis : r_to_halt;
  assign w_eff_tgt  = w_any ? w_tgt : r_tgt;

  msrv32_next_pc u_next_pc (
    .i_trap      (trap_taken_in),
    .i_trap_addr (trap_addr_in),
    .i_branch    (branch_taken_in),
    .i_target    (target_addr_in),
    .i_pc        (r_pc),
    .i_adv       (w_adv),
    .o_redir     (w_redir),
    .o_mis       (w_mis),
    .o_tgt       (w_tgt),
    .o_next_pc   (w_next_pc)
  );

  assign imem_req_out        = (r_state == S_REQ);
  assign imem_addr_out       = r_pc;
  assign instr_valid_out     = (r_state == S_HOLD);
  assign instr_out           = r_instr;
  assign pc_out              = r_pc_out;
  assign misaligned_exc_out  = r_mis_exc;
  assign misaligned_addr_out = r_mis_addr;

  // fetch FSM, PC, captured instruction, exception flag
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      r_state    <= S_IDLE;
      r_pc       <= BOOT_ADDR;
      r_tgt      <= BOOT_ADDR;
      r_to_halt  <= 1'b0;
      r_pend     <= 1'b0;
      r_instr    <= NOP;
      r_pc_out   <= BOOT_ADDR;
      r_mis_exc  <= 1'b0;
      r_mis_addr <= 32'h0;
    end else begin
      r_mis_exc <= w_mis;
      if (w_mis) r_mis_addr <= target_addr_in;
      case (r_state)
        S_IDLE: begin
          if (w_redir) r_pc <= w_tgt;
          r_state <= w_mis ? S_HALT : S_REQ;
        end
        S_REQ: begin
          if (w_any) begin
            r_tgt     <= w_tgt;
            r_to_halt <= w_mis;
          end
          if (imem_gnt_in) begin
            r_pend  <= 1'b0;
            r_state <= (r_pend | w_any) ? S_DROP : S_WAIT;
          end else if (w_any) begin
            r_pend <= 1'b1;
          end
        end
        S_WAIT: begin
          if (w_any) begin
            if (imem_rvalid_in) begin
              if (w_redir) r_pc <= w_tgt;
              r_state <= w_mis ? S_HALT : S_REQ;
            end else begin
              r_tgt     <= w_tgt;
              r_to_halt <= w_mis;
              r_state   <= S_DROP;
            end
          end else if (imem_rvalid_in) begin
            r_instr  <= imem_rdata_in;
            r_pc_out <= r_pc;
            r_state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_mis) begin
            r_state <= S_HALT;
          end else if (w_redir | ~stall_in) begin
            r_pc    <= w_next_pc;
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (w_any) begin
            r_tgt     <= w_tgt;
            r_to_halt <= w_mis;
          end
          if (imem_rvalid_in) begin
            if (w_eff_halt) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= w_eff_tgt;
              r_state <= S_REQ;
            end
          end
        end
        S_HALT: begin
          if (trap_taken_in) begin
            r_pc    <= w_tgt;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Bench for msrv32_fetch_ctrl.
// Cycle table, imem responder, scoreboards.
module tb_msrv32_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br, trap, stall;
  logic [31:0] tgt, trap_addr;
  logic        req, gnt, rvalid;
  logic [31:0] addr, rdata;
  logic        vld, exc;
  logic [31:0] instr, pco, maddr;

  int checks = 0;
  int failures = 0;

  logic        gnt_en, rv_en;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;

  logic [31:0] exp_gnt[$];
  logic [31:0] exp_dlv[$];

  typedef struct {
    logic        g;
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        rq;
    logic [31:0] a;
    logic        v;
    logic [31:0] p;
  } vec_t;

  vec_t tbl[28];

  always #5 clk = ~clk;

  msrv32_fetch_ctrl #(.BOOT_ADDR(32'h0)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .branch_taken_in        (br),
    .target_addr_in         (tgt),
    .trap_taken_in          (trap),
    .trap_addr_in           (trap_addr),
    .stall_in               (stall),
    .imem_req_out           (req),
    .imem_addr_out          (addr),
    .imem_gnt_in            (gnt),
    .imem_rvalid_in         (rvalid),
    .imem_rdata_in          (rdata),
    .instr_valid_out        (vld),
    .instr_out              (instr),
    .pc_out                 (pco),
    .misaligned_exc_out     (exc),
    .misaligned_addr_out    (maddr)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic put(input int i, input logic g, input logic s,
                     input logic b, input logic [31:0] t,
                     input logic rq, input logic [31:0] a,
                     input logic v, input logic [31:0] p);
    tbl[i] = '{g, s, b, t, rq, a, v, p};
  endtask

  task automatic chk_reset();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_vld", {31'h0, vld}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pco, 32'h0);
    chk("rst_exc", {31'h0, exc}, 32'h0);
    chk("rst_maddr", maddr, 32'h0);
  endtask

  // imem model: grant per gnt_en, respond one cycle later
  initial begin
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      rvalid = 1'b0;
      rdata = 32'h0;
      if (pend && rv_en) begin
        rvalid = 1'b1;
        rdata = word(pend_addr);
        pend = 1'b0;
      end
      gnt = req && gnt_en;
      if (gnt) begin
        pend = 1'b1;
        pend_addr = addr;
        if (exp_gnt.size() == 0) begin
          chk("gnt_unexpected", addr, 32'hFFFF_FFFF);
        end else begin
          chk("gnt_addr", addr, exp_gnt.pop_front());
        end
      end
    end
  end

  // delivery scoreboard: one compare per HOLD entry
  initial begin
    logic pv;
    logic [31:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (vld && !pv) begin
        if (exp_dlv.size() == 0) begin
          chk("dlv_unexpected", pco, 32'hFFFF_FFFF);
        end else begin
          e = exp_dlv.pop_front();
          chk("dlv_pc", pco, e);
          chk("dlv_instr", instr, word(e));
        end
      end
      pv = vld;
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    br = 1'b0;
    trap = 1'b0;
    stall = 1'b0;
    tgt = 32'h0;
    trap_addr = 32'h0;
    gnt_en = 1'b1;
    rv_en = 1'b1;

    exp_gnt = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100,
                32'h104, 32'h200, 32'h204, 32'h800, 32'h0};
    exp_dlv = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h200, 32'h0};

    //      i  gnt st br tgt      req addr     v  pc
    put( 0, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    put( 1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put( 2, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
    put( 3, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    put( 4, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put( 5, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h4);
    put( 6, 1, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0);
    put( 7, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put( 8, 0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h8);
    put( 9, 0, 0, 1, 32'h100, 1, 32'hC,   0, 32'h0);
    put(10, 0, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    put(11, 0, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    put(12, 1, 0, 0, 32'h0,   1, 32'hC,   0, 32'h0);
    put(13, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put(14, 1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    put(15, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put(16, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h100);
    put(17, 1, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    put(18, 1, 0, 1, 32'h200, 0, 32'h0,   0, 32'h0);
    put(19, 1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    put(20, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
    put(21, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(22, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(23, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(24, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(25, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(26, 1, 0, 0, 32'h0,   0, 32'h0,   1, 32'h200);
    put(27, 0, 0, 0, 32'h0,   1, 32'h204, 0, 32'h0);

    repeat (2) @(negedge clk);
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      chk($sformatf("t%0d_req", i), {31'h0, req}, {31'h0, tbl[i].rq});
      if (tbl[i].rq)
        chk($sformatf("t%0d_addr", i), addr, tbl[i].a);
      chk($sformatf("t%0d_vld", i), {31'h0, vld}, {31'h0, tbl[i].v});
      if (tbl[i].v) begin
        chk($sformatf("t%0d_pc", i), pco, tbl[i].p);
        chk($sformatf("t%0d_instr", i), instr, word(tbl[i].p));
      end
      gnt_en = tbl[i].g;
      stall = tbl[i].s;
      br = tbl[i].b;
      tgt = tbl[i].t;
    end

    // misaligned branch while REQ is ungranted
    @(negedge clk);
    br = 1'b1;
    tgt = 32'h102;
    @(negedge clk);
    chk("mis_exc_hi", {31'h0, exc}, 32'h1);
    chk("mis_addr", maddr, 32'h102);
    chk("mis_req_hold", {31'h0, req}, 32'h1);
    chk("mis_addr_hold", addr, 32'h204);
    br = 1'b0;
    tgt = 32'h0;
    gnt_en = 1'b1;
    @(negedge clk);
    chk("mis_exc_lo", {31'h0, exc}, 32'h0);
    chk("drop_req", {31'h0, req}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("halt%0d_req", k), {31'h0, req}, 32'h0);
      chk($sformatf("halt%0d_vld", k), {31'h0, vld}, 32'h0);
    end
    chk("halt_maddr", maddr, 32'h102);
    trap = 1'b1;
    trap_addr = 32'h803;
    @(negedge clk);
    trap = 1'b0;
    trap_addr = 32'h0;
    chk("trap_req", {31'h0, req}, 32'h1);
    chk("trap_addr", addr, 32'h800);

    // reset during WAIT; stale rvalid lands in IDLE
    @(negedge clk);
    rv_en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rv_en = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'h0, req}, 32'h1);
    chk("post_rst_addr", addr, 32'h0);

    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      #3;
      seen = vld;
    end
    chk("post_rst_dlv_seen", {31'h0, 31'h0, seen}, 32'h1);
    @(negedge clk);
    chk("gnt_q_empty", exp_gnt.size(), 32'h0);
    chk("dlv_q_empty", exp_dlv.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
